// File: rtl/airi5c_muldiv_unit.sv
// airi5c_muldiv_unit: iterative RV M-extension PCPI unit; optional result cache via MULDIV_RESULT_CACHE_EN
module airi5c_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int MUL_STEP = 8
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);
  localparam int CW = $clog2(XLEN + 1);
  localparam int MUL_CYC = XLEN / MUL_STEP;
  typedef enum logic [2:0] {IDLE, PREP, MUL, DIV, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, m_q, m_d;
  logic [2*XLEN-1:0] acc_q, acc_d, pair;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] f3_q, f3_d;
  logic negq_q, negq_d, negr_q, negr_d;
  logic dec, accept, abort, hit, s1, s2, ge, lo_sel, unused_ok;
  logic [XLEN-1:0] mag1, mag2, q_fix, r_fix;
  logic [XLEN+MUL_STEP-1:0] pp;
  logic [XLEN:0] rem_t, rem_n;
`ifdef MULDIV_RESULT_CACHE_EN
  logic c_valid_q, c_valid_d;
  logic [XLEN-1:0] c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d;
  logic [2:0] c_grp_q, c_grp_d;
  logic [2*XLEN-1:0] c_pair_q, c_pair_d;
  function automatic logic [2:0] grp_of(input logic [2:0] f);
    return f[2] ? (f[0] ? 3'd5 : 3'd4) : (f == 3'd1 ? 3'd0 : f);
  endfunction
  assign hit = c_valid_q && pcpi_rs1 == c_rs1_q && pcpi_rs2 == c_rs2_q && grp_of(pcpi_insn[14:12]) == c_grp_q;
`else
  assign hit = 1'b0;
`endif
  assign unused_ok = ^{pcpi_insn[24:15], pcpi_insn[11:7]};
  assign dec = pcpi_insn[6:0] == 7'h33 && pcpi_insn[31:25] == 7'h01;
  assign accept = nreset && state_q == IDLE && pcpi_valid && dec;
  assign abort = !pcpi_valid && state_q != IDLE && state_q != DONE;
  assign pcpi_wait = accept || (state_q != IDLE && state_q != DONE);
  assign pcpi_ready = state_q == DONE;
  assign pcpi_wr = pcpi_ready;
  assign lo_sel = f3_q == 3'd0 || f3_q[2:1] == 2'b10;
  assign pcpi_rd = !pcpi_ready ? '0 : lo_sel ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
  // operand signs/magnitudes, one multiply/divide step and final sign fixup
  always_comb begin
    s1 = rs1_q[XLEN-1] && (!f3_q[0] || f3_q == 3'd1);
    s2 = rs2_q[XLEN-1] && ((!f3_q[0] && f3_q != 3'd2) || f3_q == 3'd1);
    mag1 = s1 ? -rs1_q : rs1_q;
    mag2 = s2 ? -rs2_q : rs2_q;
    pp = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} + {{MUL_STEP{1'b0}}, m_q} * {{XLEN{1'b0}}, acc_q[MUL_STEP-1:0]};
    rem_t = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    ge = rem_t >= {1'b0, m_q};
    rem_n = ge ? rem_t - {1'b0, m_q} : rem_t;
    q_fix = negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    r_fix = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    pair = f3_q[2] ? {r_fix, q_fix} : negq_q ? -acc_q : acc_q;
  end
  // next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    m_d = m_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    f3_d = f3_q;
    negq_d = negq_q;
    negr_d = negr_q;
`ifdef MULDIV_RESULT_CACHE_EN
    c_valid_d = c_valid_q;
    c_rs1_d = c_rs1_q;
    c_rs2_d = c_rs2_q;
    c_grp_d = c_grp_q;
    c_pair_d = c_pair_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        rs1_d = pcpi_rs1;
        rs2_d = pcpi_rs2;
        f3_d = pcpi_insn[14:12];
        state_d = hit ? DONE : PREP;
`ifdef MULDIV_RESULT_CACHE_EN
        if (hit) acc_d = c_pair_q;
`endif
      end
      PREP: if (!f3_q[2]) begin
        m_d = mag1;
        acc_d = {{XLEN{1'b0}}, mag2};
        negq_d = s1 ^ s2;
        negr_d = 1'b0;
        cnt_d = CW'(MUL_CYC - 1);
        state_d = MUL;
      end else if (rs2_q == '0) begin
        acc_d = {rs1_q, {XLEN{1'b1}}};
        negq_d = 1'b0;
        negr_d = 1'b0;
        state_d = FIX;
      end else begin
        m_d = mag2;
        acc_d = {{XLEN{1'b0}}, mag1};
        negq_d = s1 ^ s2;
        negr_d = s1;
        cnt_d = CW'(XLEN - 1);
        state_d = DIV;
      end
      MUL: begin
        acc_d = {pp, acc_q[XLEN-1:MUL_STEP]};
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? FIX : MUL;
      end
      DIV: begin
        acc_d = {rem_n[XLEN-1:0], acc_q[XLEN-2:0], ge};
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? FIX : DIV;
      end
      FIX: begin
        acc_d = pair;
        state_d = DONE;
`ifdef MULDIV_RESULT_CACHE_EN
        c_valid_d = 1'b1;
        c_rs1_d = rs1_q;
        c_rs2_d = rs2_q;
        c_grp_d = grp_of(f3_q);
        c_pair_d = pair;
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
`ifdef MULDIV_RESULT_CACHE_EN
      c_valid_d = 1'b0;
`endif
    end
  end
  // state and datapath registers, cleared by asynchronous reset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      rs1_q <= '0;
      rs2_q <= '0;
      m_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      f3_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
`ifdef MULDIV_RESULT_CACHE_EN
      c_valid_q <= 1'b0;
      c_rs1_q <= '0;
      c_rs2_q <= '0;
      c_grp_q <= '0;
      c_pair_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      m_q <= m_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      f3_q <= f3_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
`ifdef MULDIV_RESULT_CACHE_EN
      c_valid_q <= c_valid_d;
      c_rs1_q <= c_rs1_d;
      c_rs2_q <= c_rs2_d;
      c_grp_q <= c_grp_d;
      c_pair_q <= c_pair_d;
`endif
    end
  end
endmodule

// File: tb/tb_airi5c_muldiv_unit.sv
// tb_airi5c_muldiv_unit: directed checks of airi5c_muldiv_unit (XLEN=32, MUL_STEP=8)
module tb_airi5c_muldiv_unit;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;
  logic pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  int tests = 0;
  int fails = 0;
  airi5c_muldiv_unit #(.XLEN(32), .MUL_STEP(8)) dut (
    .clk(clk), .nreset(nreset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] insn_of(input logic [2:0] f3);
    return {7'h01, 10'd0, f3, 5'd0, 7'h33};
  endfunction
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] rd);
    lat = -1;
    rd = '0;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn = insn_of(f3);
    pcpi_rs1 = a;
    pcpi_rs2 = b;
    #1 chk("wait_accept", pcpi_wait, 1);
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        pcpi_rs1 = $urandom;
        pcpi_rs2 = $urandom;
      end
      if (pcpi_ready) begin
        lat = k;
        rd = pcpi_rd;
        chk("wr_with_ready", pcpi_wr, 1);
        pcpi_valid = 1'b0;
      end else chk("rd_zero_busy", pcpi_rd, 0);
    end
    pcpi_valid = 1'b0;
    if (lat < 0) chk("timeout", 0, 1);
    @(posedge clk);
    #1 chk("ready_one_cycle", pcpi_ready, 0);
  endtask
  task automatic no_ready(input string tag, input int n);
    logic seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1 seen = seen | pcpi_ready | pcpi_wr;
    end
    chk(tag, seen, 0);
  endtask
  initial begin
    int lat;
    logic [31:0] rd;
    longint sa, sb;
    logic [63:0] prod;
    pcpi_valid = 1'b1;
    pcpi_insn = insn_of(3'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait", pcpi_wait, 0);
    chk("rst_ready", pcpi_ready, 0);
    chk("rst_wr", pcpi_wr, 0);
    chk("rst_rd", pcpi_rd, 0);
    @(negedge clk);
    pcpi_valid = 1'b0;
    nreset = 1'b1;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn = {7'h01, 10'd0, 3'd0, 5'd0, 7'h13};
    #1 chk("undecoded_wait", pcpi_wait, 0);
    no_ready("undecoded_no_ready", 5);
    chk("undecoded_idle_wait", pcpi_wait, 0);
    pcpi_valid = 1'b0;
    run_op(3'd0, 32'hFFFFFFFF, 32'h00000002, lat, rd);
    chk("mul_lat", lat, 7);
    chk("mul_rd", rd, 32'hFFFFFFFE);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, rd);
    chk("mulhu_rd", rd, 32'hFFFFFFFE);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, rd);
    chk("mulhsu_rd", rd, 32'hFFFFFFFF);
    sa = int'(32'h12345678);
    sb = int'(32'h9ABCDEF0);
    prod = sa * sb;
    run_op(3'd1, 32'h12345678, 32'h9ABCDEF0, lat, rd);
    chk("mulh_rd", rd, prod[63:32]);
    chk("mulh_lat", lat, 7);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, lat, rd);
    chk("div_lat", lat, 35);
    chk("div_rd", rd, 32'hFFFFFFFD);
    run_op(3'd0, 32'd1, 32'd1, lat, rd);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, lat, rd);
    chk("rem_rd", rd, 32'hFFFFFFFF);
    run_op(3'd5, 32'd100, 32'd7, lat, rd);
    chk("divu_rd", rd, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, lat, rd);
    chk("remu_rd", rd, 32'd2);
    run_op(3'd4, 32'd5, 32'd0, lat, rd);
    chk("div0_lat", lat, 3);
    chk("div0_rd", rd, 32'hFFFFFFFF);
    run_op(3'd6, 32'd5, 32'd0, lat, rd);
    chk("rem0_rd", rd, 32'd5);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, lat, rd);
    chk("div_ovf_rd", rd, 32'h80000000);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, lat, rd);
    chk("rem_ovf_rd", rd, 32'd0);
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn = insn_of(3'd5);
    pcpi_rs1 = 32'd1000;
    pcpi_rs2 = 32'd3;
    repeat (10) @(posedge clk);
    #1 pcpi_valid = 1'b0;
    chk("abort_busy", pcpi_wait, 1);
    @(posedge clk);
    #1 chk("abort_idle", pcpi_wait, 0);
    no_ready("abort_no_ready", 40);
    run_op(3'd0, 32'd3, 32'd4, lat, rd);
    chk("mul_after_abort", rd, 32'd12);
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn = insn_of(3'd4);
    pcpi_rs1 = 32'd77;
    pcpi_rs2 = 32'd5;
    repeat (5) @(posedge clk);
    #1 nreset = 1'b0;
    pcpi_valid = 1'b0;
    #1 chk("midrst_wait", pcpi_wait, 0);
    @(negedge clk);
    nreset = 1'b1;
    no_ready("midrst_no_ready", 40);
`ifdef MULDIV_RESULT_CACHE_EN
    run_op(3'd1, 32'h12345678, 32'h9ABCDEF0, lat, rd);
    chk("cache_mulh_rd", rd, prod[63:32]);
    run_op(3'd0, 32'h12345678, 32'h9ABCDEF0, lat, rd);
    chk("cache_hit_lat", lat, 1);
    chk("cache_hit_rd", rd, prod[31:0]);
    run_op(3'd3, 32'h12345678, 32'h9ABCDEF0, lat, rd);
    chk("cache_miss_lat", lat, 7);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/airi5c_muldiv_unit.md
AIRI5C_MULDIV_UNIT -- requirements
Module: airi5c_muldiv_unit

Interface
REQ-001 SHALL use parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 SHALL use parameter MUL_STEP, default 8, multiplier bits consumed per cycle (1, 2, 4, 8, 16; divides XLEN).
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port nreset, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port pcpi_valid, input, 1, instruction offered; deassertion mid-operation = abort.
REQ-006 SHALL have port pcpi_insn, input, 32, instruction word.
REQ-007 SHALL have ports pcpi_rs1 and pcpi_rs2, input, XLEN each, operands.
REQ-008 SHALL have port pcpi_wr, output, 1, rd write enable.
REQ-009 SHALL have port pcpi_rd, output, XLEN, result.
REQ-010 SHALL have port pcpi_wait, output, 1, busy indication.
REQ-011 SHALL have port pcpi_ready, output, 1, result valid.

Function
REQ-012 SHALL decode only opcode 7'h33 with funct7 7'h01; funct3 0-7 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; any other insn is ignored (wait=0, no state change).
REQ-013 SHALL have FSM states IDLE, PREP, MUL, DIV, FIX, DONE.
- IDLE->PREP on pcpi_valid & decoded (accept cycle A).
- PREP->MUL or DIV.
- MUL/DIV->FIX after the final step.
- FIX->DONE.
- DONE->IDLE.
REQ-014 SHALL drive pcpi_wait combinationally high in cycle A and in every non-IDLE state except DONE.
REQ-015 SHALL latch rs1, rs2 and funct3 in cycle A; later operand changes SHALL be ignored.
REQ-016 PREP SHALL convert signed operands to magnitudes and record the result sign.
- MUL/MULH: both operands signed.
- MULHSU: rs1 signed only.
- DIV: quotient sign = rs1 sign XOR rs2 sign.
- REM: remainder sign = rs1 sign.
REQ-017 MUL state SHALL run shift-add over MUL_STEP bits per cycle into a 2*XLEN accumulator, taking XLEN/MUL_STEP cycles.
REQ-018 DIV state SHALL run restoring radix-2 division, one quotient bit per cycle, taking XLEN cycles.
REQ-019 FIX SHALL apply two's-complement sign correction and select the output.
- MUL: low XLEN bits.
- MULH, MULHSU, MULHU: high XLEN bits.
- DIV, DIVU: quotient.
- REM, REMU: remainder.
REQ-020 Latency SHALL be:
- multiply: ready in cycle A+3+XLEN/MUL_STEP.
- divide: ready in cycle A+3+XLEN.
REQ-021 Divide by zero SHALL bypass DIV (PREP->FIX) and reach ready in cycle A+3.
- quotient = all ones.
- remainder = rs1.
REQ-022 Signed overflow (rs1 = most negative value, rs2 = -1) SHALL give quotient = rs1 and remainder = 0.
REQ-023 DONE SHALL assert pcpi_ready and pcpi_wr for exactly one cycle with pcpi_rd = result.
REQ-024 pcpi_rd SHALL be 0 whenever pcpi_ready is low (wired-OR bus).
REQ-025 If pcpi_valid drops in any state other than IDLE or DONE, the FSM SHALL return to IDLE next cycle with no ready or wr pulse.
REQ-026 A new instruction SHALL be accepted no earlier than the cycle after DONE.

Reset
REQ-027 While nreset is low, the block SHALL hold:
- FSM in IDLE.
- pcpi_wr, pcpi_wait, pcpi_ready = 0; pcpi_rd = 0.
- accumulator, operand and step-counter registers = 0.
- cache valid bit = 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation; no ready pulse SHALL follow reset release.

Configuration
REQ-029 Macro MULDIV_RESULT_CACHE_EN: when defined, each completed operation SHALL store rs1, rs2, operation group and the full result pair.
- Groups: {MUL,MULH}, {MULHSU}, {MULHU}, {DIV,REM}, {DIVU,REMU}.
- The result pair is the 2*XLEN product, or quotient plus remainder.
- A later accepted instruction in the same group with identical operands SHALL go directly to DONE, giving ready in cycle A+1.
- Abort and reset SHALL clear the cache valid bit.
REQ-030 When MULDIV_RESULT_CACHE_EN is undefined, no cache storage SHALL exist and every operation SHALL take the latency of REQ-020/REQ-021.

Verification
REQ-031 MUL rs1=0xFFFFFFFF, rs2=0x00000002 (XLEN=32, MUL_STEP=8) -> ready at A+7, rd=0xFFFFFFFE.
REQ-032 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> rd=0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> rd=0xFFFFFFFF.
REQ-033 DIV -7/2 -> ready at A+35, rd=0xFFFFFFFD; REM -7/2 -> rd=0xFFFFFFFF.
REQ-034 DIV by zero with rs1=5 -> ready at A+3, rd=0xFFFFFFFF; REM by zero -> rd=5.
- DIV 0x80000000 / 0xFFFFFFFF -> rd=0x80000000.
REQ-035 Abort case: DIVU started, pcpi_valid dropped at A+10 -> IDLE at A+11, no ready pulse.
- A following MUL 3x4 -> rd=12.
REQ-036 With MULDIV_RESULT_CACHE_EN: MULH 0x12345678 x 0x9ABCDEF0, then MUL with the same operands -> second ready at A+1 with the low product.
- A following MULHU with the same operands -> full latency.
